// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: phase codes, lamp one-hots, 7-segment glyphs,
// the display saturation limit and the BCD converter state type.
package tl_pkg;

  localparam logic [1:0] OFF     = 2'd0;
  localparam logic [1:0] LEFT    = 2'd1;
  localparam logic [1:0] FORWARD = 2'd2;
  localparam logic [1:0] RIGHT   = 2'd3;

  localparam logic [3:0] LAMP_STOP    = 4'b0001;
  localparam logic [3:0] LAMP_LEFT    = 4'b0010;
  localparam logic [3:0] LAMP_FORWARD = 4'b0100;
  localparam logic [3:0] LAMP_RIGHT   = 4'b1000;

  // Segment order {g,f,e,d,c,b,a}, bit0 = a, active-high.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam int unsigned SAT_LIMIT = 99;

  typedef enum logic [1:0] {
    CV_IDLE  = 2'd0,
    CV_LOAD  = 2'd1,
    CV_SHIFT = 2'd2,
    CV_STORE = 2'd3
  } cv_state_t;

  function automatic logic [3:0] lamp_decode(input logic [1:0] ph);
    case (ph)
      LEFT:    return LAMP_LEFT;
      FORWARD: return LAMP_FORWARD;
      RIGHT:   return LAMP_RIGHT;
      default: return LAMP_STOP;
    endcase
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/tl_bin2bcd.sv
// Sequential 7-bit binary to two-digit BCD converter (shift-add-3, one bit per cycle).
// Handshake: while i_start is high the converter runs back to back; o_done is high
// for the single STORE cycle in which o_tens/o_ones hold the finished result.
module tl_bin2bcd
  import tl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [6:0] i_bin,
  output logic       o_done,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output cv_state_t  o_state
);

  cv_state_t  r_state;
  cv_state_t  w_next;
  logic [6:0] r_bin;
  logic [7:0] r_bcd;
  logic [2:0] r_iter;
  logic [7:0] w_adj;

  // Add-3 correction on each nibble before the shift so it carries correctly.
  always_comb begin
    w_adj[3:0] = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
    w_adj[7:4] = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      CV_IDLE:  if (i_start) w_next = CV_LOAD;
      CV_LOAD:  w_next = CV_SHIFT;
      CV_SHIFT: if (r_iter == 3'd6) w_next = CV_STORE;
      CV_STORE: w_next = i_start ? CV_LOAD : CV_IDLE;
      default:  w_next = CV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CV_IDLE;
      r_bin   <= 7'd0;
      r_bcd   <= 8'd0;
      r_iter  <= 3'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        CV_LOAD: begin
          r_bin  <= i_bin;
          r_bcd  <= 8'd0;
          r_iter <= 3'd0;
        end
        CV_SHIFT: begin
          r_bcd  <= {w_adj[6:0], r_bin[6]};
          r_bin  <= {r_bin[5:0], 1'b0};
          r_iter <= r_iter + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_done  = (r_state == CV_STORE);
  assign o_tens  = r_bcd[7:4];
  assign o_ones  = r_bcd[3:0];
  assign o_state = r_state;

endmodule

// File: rtl/tl_display_driver.sv
// Traffic-light display driver: lamp decode, countdown to BCD, 4-digit 7-segment scan.
// Optional last-seconds lamp flashing is enabled by defining TL_LAST_FLASH_EN.
module tl_display_driver
  import tl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       phase_a,
  input  logic [CNT_W-1:0] count_a,
  input  logic [1:0]       phase_b,
  input  logic [CNT_W-1:0] count_b,
  output logic [3:0]       lamp_a,
  output logic [3:0]       lamp_b,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             bcd_valid
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  if (SCAN_DIV < 2 || BLINK_DIV < 2) begin : g_bad_param
    $error("tl_display_driver: SCAN_DIV and BLINK_DIV must be at least 2");
  end

  logic [3:0]        r_lamp_a;
  logic [3:0]        r_lamp_b;
  logic              r_chan;
  logic [3:0]        r_tens_a;
  logic [3:0]        r_ones_a;
  logic [3:0]        r_tens_b;
  logic [3:0]        r_ones_b;
  logic              r_done_a;
  logic              r_done_b;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [1:0]        r_digit;
  logic [6:0]        r_seg;
  logic [3:0]        r_an;

  logic [6:0]        w_sat_a;
  logic [6:0]        w_sat_b;
  logic [6:0]        w_bin;
  logic              w_done;
  logic [3:0]        w_tens;
  logic [3:0]        w_ones;
  cv_state_t         w_cv_state;
  logic              w_store;
  logic              w_valid;
  logic [3:0]        w_digit_val;
  logic              w_blank;

  // Display saturates at 99 so the converter only ever sees 7 bits.
  assign w_sat_a = (count_a > CNT_W'(SAT_LIMIT)) ? 7'(SAT_LIMIT) : count_a[6:0];
  assign w_sat_b = (count_b > CNT_W'(SAT_LIMIT)) ? 7'(SAT_LIMIT) : count_b[6:0];
  assign w_bin   = r_chan ? w_sat_b : w_sat_a;

  tl_bin2bcd u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .i_start (1'b1),
    .i_bin   (w_bin),
    .o_done  (w_done),
    .o_tens  (w_tens),
    .o_ones  (w_ones),
    .o_state (w_cv_state)
  );

  assign w_store = w_done && (w_cv_state == CV_STORE);
  assign w_valid = r_done_a & r_done_b;

  // The single converter alternates channels; each STORE lands in the channel just converted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chan   <= 1'b0;
      r_tens_a <= 4'd0;
      r_ones_a <= 4'd0;
      r_tens_b <= 4'd0;
      r_ones_b <= 4'd0;
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
    end else if (w_store) begin
      if (!r_chan) begin
        r_tens_a <= w_tens;
        r_ones_a <= w_ones;
        r_done_a <= 1'b1;
      end else begin
        r_tens_b <= w_tens;
        r_ones_b <= w_ones;
        r_done_b <= 1'b1;
      end
      r_chan <= ~r_chan;
    end
  end

`ifdef TL_LAST_FLASH_EN
  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink;
  logic               w_flash_a;
  logic               w_flash_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Flash uses the raw count, so a saturated display never hides a real last-seconds value.
  assign w_flash_a = (phase_a != OFF) && (count_a <= CNT_W'(3));
  assign w_flash_b = (phase_b != OFF) && (count_b <= CNT_W'(3));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lamp_a <= 4'b0000;
      r_lamp_b <= 4'b0000;
    end else begin
      r_lamp_a <= lamp_decode(phase_a) & {4{r_blink | ~w_flash_a}};
      r_lamp_b <= lamp_decode(phase_b) & {4{r_blink | ~w_flash_b}};
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lamp_a <= 4'b0000;
      r_lamp_b <= 4'b0000;
    end else begin
      r_lamp_a <= lamp_decode(phase_a);
      r_lamp_b <= lamp_decode(phase_b);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_digit    <= 2'd0;
    end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_digit    <= r_digit + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Tens digits suppress a leading zero; ones digits always show.
  always_comb begin
    w_digit_val = r_ones_a;
    w_blank     = 1'b0;
    case (r_digit)
      2'd0: w_digit_val = r_ones_a;
      2'd1: begin
        w_digit_val = r_tens_a;
        w_blank     = (r_tens_a == 4'd0);
      end
      2'd2: w_digit_val = r_ones_b;
      2'd3: begin
        w_digit_val = r_tens_b;
        w_blank     = (r_tens_b == 4'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= 7'h00;
      r_an  <= 4'b0000;
    end else begin
      r_seg <= (!w_valid || w_blank) ? 7'h00 : seg_encode(w_digit_val);
      r_an  <= 4'b0001 << r_digit;
    end
  end

  assign lamp_a    = r_lamp_a;
  assign lamp_b    = r_lamp_b;
  assign seg       = r_seg;
  assign an        = r_an;
  assign bcd_valid = w_valid;

endmodule
